// File: rtl/ysyx_25030093_sram_arbiter.sv
// Shares one SRAM port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight; round-robin on simultaneous requests.
module ysyx_25030093_sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_resp_valid,
  input  logic [DATA_W-1:0]   s_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   ifu_win, lsu_win;
  logic   ifu_act, lsu_act;

  // Winner pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    ifu_win = ifu_req_valid & (~lsu_req_valid | (last_grant == OWN_LSU));
    lsu_win = lsu_req_valid & (~ifu_req_valid | (last_grant == OWN_IFU));
  end

  assign ifu_req_ready = (state == S_IDLE) & ifu_win;
  assign lsu_req_ready = (state == S_IDLE) & lsu_win;

  // Response path is combinational from the SRAM, gated to the owner in WAIT.
  assign ifu_act        = (state == S_WAIT) & (owner == OWN_IFU);
  assign lsu_act        = (state == S_WAIT) & (owner == OWN_LSU);
  assign ifu_resp_valid = ifu_act & s_resp_valid;
  assign lsu_resp_valid = lsu_act & s_resp_valid;
  assign ifu_rdata      = ifu_act ? s_rdata : '0;
  assign lsu_rdata      = lsu_act ? s_rdata : '0;

  // Arbiter FSM: grant and latch in IDLE, hold request in REQ, await data in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OWN_IFU;
      last_grant  <= OWN_LSU;
      s_req_valid <= 1'b0;
      s_addr      <= '0;
      s_wen       <= 1'b0;
      s_wdata     <= '0;
      s_wmask     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ifu_win) begin
            s_addr      <= ifu_addr;
            s_wen       <= 1'b0;
            s_wdata     <= '0;
            s_wmask     <= {(DATA_W/8){1'b1}};
            owner       <= OWN_IFU;
            last_grant  <= OWN_IFU;
            s_req_valid <= 1'b1;
            state       <= S_REQ;
          end else if (lsu_win) begin
            s_addr      <= lsu_addr;
            s_wen       <= lsu_wen;
            s_wdata     <= lsu_wdata;
            s_wmask     <= lsu_wmask;
            owner       <= OWN_LSU;
            last_grant  <= OWN_LSU;
            s_req_valid <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (s_req_ready) begin
            s_req_valid <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (s_resp_valid) state <= S_IDLE;
        end
        default: begin
          s_req_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_sram_arbiter.sv
// Directed bench for the IFU/LSU SRAM arbiter.
module tb_ysyx_25030093_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        s_req_valid, s_req_ready, s_wen, s_resp_valid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  int errs = 0;
  int nchk = 0;
  int proto_err = 0;
  logic in_wait;

  always #5 clk = ~clk;

  ysyx_25030093_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
  );

  // Protocol monitor: SRAM responses are only legal after a request handshake.
  always @(posedge clk) begin
    if (rst) in_wait <= 1'b0;
    else begin
      if (s_resp_valid && !in_wait) begin
        proto_err <= proto_err + 1;
        $display("protocol: s_resp_valid outside WAIT at %0t", $time);
      end
      if (s_req_valid && s_req_ready) in_wait <= 1'b1;
      else if (s_resp_valid) in_wait <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Called #1 after the request handshake edge; plays the SRAM side.
  task automatic serve(input int req_dly, input int resp_dly, input logic [31:0] d,
                       input logic lsu_own, input logic [31:0] ea, input logic ew,
                       input logic [31:0] ed, input logic [3:0] em);
    for (int k = 0; k <= req_dly; k++) begin
      #1;
      chk("s_req_valid", s_req_valid, 1);
      chk("s_addr", s_addr, ea);
      chk("s_wen", s_wen, ew);
      chk("s_wdata", s_wdata, ed);
      chk("s_wmask", s_wmask, em);
      chk("rdy_busy_req", {ifu_req_ready, lsu_req_ready}, 0);
      if (k == req_dly) s_req_ready = 1'b1;
      cyc();
    end
    s_req_ready = 1'b0;
    for (int k = 0; k < resp_dly; k++) begin
      #1;
      chk("s_req_once", s_req_valid, 0);
      chk("rdy_busy_wait", {ifu_req_ready, lsu_req_ready}, 0);
      chk("resp_early", {ifu_resp_valid, lsu_resp_valid}, 0);
      cyc();
    end
    s_resp_valid = 1'b1;
    s_rdata = d;
    #1;
    chk("s_req_once", s_req_valid, 0);
    chk("ifu_resp_valid", ifu_resp_valid, !lsu_own);
    chk("lsu_resp_valid", lsu_resp_valid, lsu_own);
    chk("ifu_rdata", ifu_rdata, lsu_own ? 32'h0 : d);
    chk("lsu_rdata", lsu_rdata, lsu_own ? d : 32'h0);
    chk("rdy_in_resp", {ifu_req_ready, lsu_req_ready}, 0);
    cyc();
    s_resp_valid = 1'b0;
    s_rdata = '0;
    #1;
    chk("resp_pulse", {ifu_resp_valid, lsu_resp_valid}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    int pe;
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    s_req_ready = 0; s_resp_valid = 0; s_rdata = 0;

    // Reset then IFU fetch
    do_reset();
    chk("rst_s_req_valid", s_req_valid, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wmask", s_wmask, 0);
    chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    chk("fetch_ifu_ready", ifu_req_ready, 1);
    chk("fetch_lsu_ready", lsu_req_ready, 0);
    cyc();
    ifu_req_valid = 0;
    serve(0, 0, 32'h0000_0413, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'hF);

    // Tie: both request continuously, grants alternate IFU first
    do_reset();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      logic own;
      own = i[0];
      #1;
      chk("tie_grant", {ifu_req_ready, lsu_req_ready}, own ? 2'b01 : 2'b10);
      cyc();
      serve(0, 0, 32'h1000 + i, own, own ? 32'h8000_2000 : 32'h8000_0100, 1'b0, 32'h0, 4'hF);
    end
    ifu_req_valid = 0; lsu_req_valid = 0;

    // LSU write with 4 cycles of s_req_ready held low
    cyc();
    lsu_req_valid = 1; lsu_addr = 32'h8000_1004; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;
    #1;
    chk("wr_lsu_ready", lsu_req_ready, 1);
    cyc();
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    serve(4, 0, 32'h0, 1'b1, 32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'h3);

    // Slow response with an LSU request pending the whole time
    cyc();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    #1;
    chk("slow_ifu_ready", ifu_req_ready, 1);
    cyc();
    ifu_req_valid = 0;
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0; lsu_wdata = 32'h5555_5555; lsu_wmask = 4'hF;
    serve(0, 8, 32'hCAFE_0001, 1'b0, 32'h8000_0200, 1'b0, 32'h0, 4'hF);
    chk("slow_lsu_grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
    cyc();
    lsu_req_valid = 0;
    serve(0, 0, 32'h1234_5678, 1'b1, 32'h8000_3000, 1'b0, 32'h5555_5555, 4'hF);

    // Reset mid-WAIT after an IFU grant, then a late SRAM response
    cyc();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
    #1;
    chk("mid_ifu_ready", ifu_req_ready, 1);
    cyc();
    ifu_req_valid = 0;
    s_req_ready = 1;
    cyc();
    s_req_ready = 0;
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_s_req_valid", s_req_valid, 0);
    cyc();
    s_resp_valid = 1; s_rdata = 32'hBAD0_BAD0;
    #1;
    chk("mid_late_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("mid_late_rdata", {ifu_rdata, lsu_rdata}, 0);
    cyc();
    s_resp_valid = 0; s_rdata = 0;
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    chk("mid_tie_ifu", {ifu_req_ready, lsu_req_ready}, 2'b10);
    ifu_req_valid = 0; lsu_req_valid = 0;
    cyc();

    // Spurious response in IDLE
    pe = proto_err;
    s_resp_valid = 1; s_rdata = 32'hFFFF_FFFF;
    #1;
    chk("spur_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("spur_s_req", s_req_valid, 0);
    cyc();
    s_resp_valid = 0; s_rdata = 0;
    chk("spur_flagged", proto_err - pe, 1);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0400;
    #1;
    chk("spur_still_idle", ifu_req_ready, 1);
    cyc();
    ifu_req_valid = 0;
    serve(0, 0, 32'h0000_0013, 1'b0, 32'h8000_0400, 1'b0, 32'h0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_sram_arbiter.md
# ysyx_25030093_sram_arbiter

Arbiter sharing the core's single SRAM port between the instruction-fetch unit (read-only requester) and the load/store unit (read/write requester). It sits between the IFU/LSU request interfaces and the SRAM slave. It holds one transaction in flight at a time, using a request/response valid-ready handshake on both sides. Arbitration is round-robin on simultaneous requests, so neither requester starves.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address (pc)
- ifu_resp_valid  out  1  fetch data valid, one-cycle pulse
- ifu_rdata  out  DATA_W  instruction word
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  data address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_resp_valid  out  1  LSU response valid, one-cycle pulse (read data or write ack)
- lsu_rdata  out  DATA_W  load data
- s_req_valid  out  1  request to SRAM
- s_req_ready  in  1  SRAM accepts request
- s_addr, s_wen, s_wdata, s_wmask  out  -  latched request fields
- s_resp_valid  in  1  SRAM response
- s_rdata  in  DATA_W  SRAM read data

## Operation
State machine IDLE -> REQ -> WAIT -> IDLE, with registers owner (IFU/LSU) and last_grant.

- **IDLE**
  - Winner selection: if exactly one req_valid is high, that requester wins. If both are high, the requester not equal to last_grant wins.
  - The winner's req_ready = 1 combinationally in this cycle; the loser's req_ready = 0.
  - On handshake: latch addr/wen/wdata/wmask (IFU forces wen=0, wmask=all-ones, wdata=0). Set owner = winner, last_grant = winner. Go to REQ.
- **REQ**
  - s_req_valid = 1 with the latched fields, held stable until s_req_ready.
  - On s_req_valid & s_req_ready, go to WAIT.
- **WAIT**
  - s_rdata routes combinationally to the owner's rdata.
  - The owner's resp_valid = s_resp_valid.
  - On s_resp_valid, go to IDLE.
- Both req_ready signals are 0 outside IDLE. New requests wait (masters hold valid and fields).
- The non-owner's resp_valid is always 0. rdata outputs are 0 when not the active owner in WAIT.
- s_resp_valid outside WAIT is ignored; a bench assertion flags it as a protocol error.
- Masters must accept responses unconditionally; there is no response back-pressure.

## Timing
- Reset values:
  - state = IDLE, owner = IFU, last_grant = LSU, so IFU wins the first tie.
  - All ready/valid outputs = 0.
  - Latched fields = 0.
- Reset asserted in REQ or WAIT:
  - State returns to IDLE at the next edge; the in-flight transaction is dropped.
  - No resp_valid is emitted.
  - A late s_resp_valid after reset is ignored.
- Latency, with request handshake at cycle T:
  - s_req_valid is high from T+1.
  - With s_req_ready at T+1, the state is WAIT at T+2.
  - Minimum SRAM response at T+2 gives resp_valid at T+2.
  - The state is IDLE at T+3, and the next grant is possible at T+3.
  - Minimum occupancy is 3 cycles per transaction.
- s_req_ready held low: REQ persists indefinitely with fields stable.
- A requester that drops req_valid in IDLE before handshake is simply not granted; no state change.
- A new request in the same cycle as resp_valid is not accepted (state is still WAIT). It is accepted the following cycle.

## Test plan
- **Reset then IFU fetch.** Hold rst 2 cycles, then ifu_req_valid=1, ifu_addr=0x80000000.
  - ifu_req_ready=1 in the first cycle.
  - s_req_valid at +1 with s_addr=0x80000000, s_wen=0, s_wmask=0xF.
  - SRAM returns 0x00000413 at +2: ifu_resp_valid pulse with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
- **Tie, round-robin.** Both request continuously after reset.
  - Grants alternate IFU, LSU, IFU, LSU.
  - last_grant toggles; each grant is separated by at least 3 cycles.
- **LSU write.** lsu_wen=1, addr=0x80001004, wdata=0xDEADBEEF, wmask=0x3.
  - s_* fields match exactly.
  - s_req_ready is delayed 4 cycles; fields stay stable throughout, and only one s_req handshake occurs.
  - Ack produces a single lsu_resp_valid.
- **Slow response.** s_resp_valid arrives 10 cycles after the request handshake.
  - Both req_ready signals stay 0 during the wait.
  - A pending lsu_req_valid is granted in the cycle after the response.
- **Reset mid-WAIT.** Assert rst during WAIT, then drive s_resp_valid one cycle after reset deasserts.
  - No resp_valid on either master.
  - The state is IDLE, and the next tie goes to IFU.
- **Spurious response.** s_resp_valid pulse in IDLE.
  - Ignored: no resp_valid, no state change.
  - The bench assertion fires.
